// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: digit select, active-low anodes, frame pulse.
// Optional anode blanking after each digit switch is built when DEAD_TIME_EN is defined.
module display_scan_ctrl #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned REFRESH_HZ  = 1_000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] DIGIT_MASK,
  output logic [1:0] SEL,
  output logic [3:0] AN,
  output logic       FRAME_START
);

  localparam int unsigned TICK_DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEAD_CYCLES >= TICK_DIV) begin : g_cfg_err
    $error("display_scan_ctrl: need TICK_DIV >= 2 and DEAD_CYCLES < TICK_DIV");
  end

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_next;
  logic [1:0]       sel_next;
  logic [3:0]       an_next;
  logic             fs_next;
  logic             tick;

`ifdef DEAD_TIME_EN
  localparam logic [PRE_W-1:0] DEAD_LEN = PRE_W'(DEAD_CYCLES);
`endif

  always_comb begin
    tick     = EN && (pre == PRE_LAST);
    pre_next = pre;
    if (EN) begin
      pre_next = tick ? '0 : pre + PRE_W'(1);
    end
    sel_next = tick ? SEL + 2'd1 : SEL;
    // Anodes are decoded from next-state values so they switch in the same cycle as SEL.
    an_next  = EN ? ~((4'b0001 << sel_next) & DIGIT_MASK) : '1;
`ifdef DEAD_TIME_EN
    if (pre_next < DEAD_LEN) begin
      an_next = '1;
    end
`endif
    fs_next  = tick && (SEL == 2'd3);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre         <= '0;
      SEL         <= '0;
      AN          <= '1;
      FRAME_START <= 1'b0;
    end else begin
      pre         <= pre_next;
      SEL         <= sel_next;
      AN          <= an_next;
      FRAME_START <= fs_next;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: enabled-cycle-count model plus scripted literal checks.
module tb_display_scan_ctrl;

  localparam int unsigned CLK_HZ      = 40;
  localparam int unsigned REFRESH_HZ  = 10;
  localparam int unsigned DEAD_CYCLES = 1;
  localparam int          TICK        = CLK_HZ / REFRESH_HZ;
  localparam int          FRAME       = 4 * TICK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] mask = 4'h0;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_start;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .REFRESH_HZ  (REFRESH_HZ),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .EN          (en),
    .DIGIT_MASK  (mask),
    .SEL         (sel),
    .AN          (an),
    .FRAME_START (frame_start)
  );

  always #5 clk = ~clk;

  // Model: the scan position is just the count of enabled cycles modulo one frame.
  int         cnt    = 0;
  logic [3:0] exp_an = 4'hF;
  logic       exp_fs = 1'b0;
  logic       chk_on = 1'b0;

  function automatic logic [3:0] an_of(int c, logic [3:0] m);
    int         s;
    logic [3:0] r;
    s = c / TICK;
    r = ~((4'b0001 << s) & m);
`ifdef DEAD_TIME_EN
    if ((c % TICK) < DEAD_CYCLES) r = 4'hF;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cnt    <= 0;
      exp_an <= 4'hF;
      exp_fs <= 1'b0;
    end else if (en) begin
      cnt    <= (cnt + 1) % FRAME;
      exp_an <= an_of((cnt + 1) % FRAME, mask);
      exp_fs <= ((cnt + 1) % FRAME) == 0;
    end else begin
      exp_an <= 4'hF;
      exp_fs <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_sel", {2'b00, sel}, 4'((cnt / TICK) % 4));
      check("model_an", an, exp_an);
      check("model_fs", {3'b000, frame_start}, {3'b000, exp_fs});
      check("an_onehot", ($countones(~an) <= 1) ? 4'd1 : 4'd0, 4'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"}, {2'b00, sel}, 4'd0);
    check({tag, "_an"}, an, 4'b1111);
    check({tag, "_fs"}, {3'b000, frame_start}, 4'd0);
  endtask

  initial begin
    // Test 1: basic scan
    rst = 1'b1; en = 1'b0; mask = 4'h0;
    step();
    chk_on = 1'b1;
    step();
    check_reset_vals("reset");
    rst = 1'b0; en = 1'b1; mask = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 4) begin
        check("t1_sel_k4", {2'b00, sel}, 4'd1);
`ifdef DEAD_TIME_EN
        check("t1_an_k4", an, 4'b1111);
`else
        check("t1_an_k4", an, 4'b1101);
`endif
      end
      if (k == 5) begin
        check("t1_sel_k5", {2'b00, sel}, 4'd1);
        check("t1_an_k5", an, 4'b1101);
      end
      if (k == 10) check("t1_an_k10", an, 4'b1011);
      if (k == 15) begin
        check("t1_sel_k15", {2'b00, sel}, 4'd3);
        check("t1_an_k15", an, 4'b0111);
        check("t1_fs_k15", {3'b000, frame_start}, 4'd0);
      end
      if (k == 16) begin
        check("t1_fs_k16", {3'b000, frame_start}, 4'd1);
        check("t1_sel_k16", {2'b00, sel}, 4'd0);
      end
      if (k == 17) begin
        check("t1_fs_k17", {3'b000, frame_start}, 4'd0);
        check("t1_an_k17", an, 4'b1110);
      end
    end

    // Test 2: masking over one full scan (count now at 4)
    mask = 4'b0101;
    for (int j = 1; j <= FRAME; j++) begin
      step();
      case ((4 + j) % FRAME)
        1:  check("t2_an_d0", an, 4'b1110);
        5:  check("t2_an_d1", an, 4'b1111);
        9:  check("t2_an_d2", an, 4'b1011);
        13: check("t2_an_d3", an, 4'b1111);
        default: ;
      endcase
    end
    mask = 4'hF;
    step();
    check("t2_an_full", an, 4'b1101);
    mask = 4'h0;
    step();
    check("t2_an_mask0", an, 4'b1111);
    check("t2_sel_mask0", {2'b00, sel}, 4'd1);

    // Test 3: pause at SEL=2, PRE=1
    rst = 1'b1;
    step();
    rst = 1'b0; mask = 4'hF; en = 1'b1;
    repeat (9) step();
    check("t3_sel_pre", {2'b00, sel}, 4'd2);
    en = 1'b0;
    step();
    check("t3_an_pause", an, 4'b1111);
    check("t3_sel_pause", {2'b00, sel}, 4'd2);
    repeat (4) step();
    check("t3_sel_hold", {2'b00, sel}, 4'd2);
    en = 1'b1;
    step();
    check("t3_sel_r1", {2'b00, sel}, 4'd2);
    check("t3_an_r1", an, 4'b1011);
    step();
    check("t3_sel_r2", {2'b00, sel}, 4'd2);
    check("t3_an_r2", an, 4'b1011);
    step();
    check("t3_sel_r3", {2'b00, sel}, 4'd3);

    // Test 4: reset mid-operation while SEL=3
    step();
    check("t4_sel_pre", {2'b00, sel}, 4'd3);
    check("t4_an_pre", an, 4'b0111);
    rst = 1'b1;
    step();
    check_reset_vals("t4_midrst");
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) check("t4_fs_k15", {3'b000, frame_start}, 4'd0);
      if (k == 16) check("t4_fs_k16", {3'b000, frame_start}, 4'd1);
    end

    // Randomized soak against the model
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0;
    step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
